// File: rtl/wb_arbiter.sv
// Write-back arbiter: shares the register-file write port between the ex stage and a buffered long-latency result.
// Optional macro WB_BYPASS_EN lets an idle-port long-latency result write in its handshake cycle.
module wb_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic [31:0] ex_rd_data_i,
    input  logic        ex_reg_wen_i,
    input  logic        ll_valid_i,
    output logic        ll_ready_o,
    input  logic [4:0]  ll_rd_addr_i,
    input  logic [31:0] ll_rd_data_i,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    output logic        reg_wen_o,
    output logic        hold_o,
    output logic        ll_pending_o
);

    localparam int unsigned AW  = 5;
    localparam int unsigned DW  = 32;
    localparam int unsigned CW  = 4;
    localparam int unsigned CW1 = CW + 1;
    localparam logic [CW-1:0] CNT_MAX    = '1;
    localparam logic [CW:0]   MAX_WAIT_W = CW1'(MAX_WAIT);

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_EX,
        SRC_BUF,
        SRC_LL
    } src_e;

    logic          r_buf_full;
    logic [AW-1:0] r_buf_addr;
    logic [DW-1:0] r_buf_data;
    logic [CW-1:0] r_wait_cnt;
    logic          r_hold;

    src_e          w_src;
    logic          w_ex_req;
    logic          w_ll_nz;
    logic          w_xfer;
    logic          w_load;
    logic          w_buf_grant;
    logic [CW:0]   w_cnt_inc;

    assign w_ex_req    = ex_reg_wen_i && (ex_rd_addr_i != '0);
    assign w_ll_nz     = ll_rd_addr_i != '0;
    assign ll_ready_o  = !rst && !r_buf_full;
    assign w_xfer      = ll_valid_i && ll_ready_o;
    // A bypassed or x0 transfer completes the handshake without occupying the buffer
    assign w_load      = w_xfer && w_ll_nz && (w_src != SRC_LL);
    assign w_buf_grant = (w_src == SRC_BUF);
    assign w_cnt_inc   = {1'b0, r_wait_cnt} + CW1'(1);
    assign hold_o      = r_hold;
    assign ll_pending_o = r_buf_full;

    // Grant selection: forced drain, then ex, then buffer, then optional bypass
    always_comb begin
        w_src = SRC_NONE;
        if (rst) begin
            w_src = SRC_NONE;
        end else if (r_hold) begin
            w_src = SRC_BUF;
        end else if (w_ex_req) begin
            w_src = SRC_EX;
        end else if (r_buf_full) begin
            w_src = SRC_BUF;
`ifdef WB_BYPASS_EN
        end else if (ll_valid_i && w_ll_nz) begin
            w_src = SRC_LL;
`endif
        end
    end

    // Write-port mux
    always_comb begin
        reg_wen_o = 1'b0;
        rd_addr_o = '0;
        rd_data_o = '0;
        case (w_src)
            SRC_EX: begin
                reg_wen_o = 1'b1;
                rd_addr_o = ex_rd_addr_i;
                rd_data_o = ex_rd_data_i;
            end
            SRC_BUF: begin
                reg_wen_o = 1'b1;
                rd_addr_o = r_buf_addr;
                rd_data_o = r_buf_data;
            end
`ifdef WB_BYPASS_EN
            SRC_LL: begin
                reg_wen_o = 1'b1;
                rd_addr_o = ll_rd_addr_i;
                rd_data_o = ll_rd_data_i;
            end
`endif
            default: begin
                reg_wen_o = 1'b0;
            end
        endcase
    end

    // Holding buffer, starvation counter and one-cycle hold pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_full <= 1'b0;
            r_buf_addr <= '0;
            r_buf_data <= '0;
            r_wait_cnt <= '0;
            r_hold     <= 1'b0;
        end else begin
            r_hold <= 1'b0;
            if (w_buf_grant) begin
                r_buf_full <= 1'b0;
                r_wait_cnt <= '0;
            end else if (w_load) begin
                r_buf_full <= 1'b1;
                r_buf_addr <= ll_rd_addr_i;
                r_buf_data <= ll_rd_data_i;
                r_wait_cnt <= '0;
            end else if (r_buf_full) begin
                if (r_wait_cnt != CNT_MAX) begin
                    r_wait_cnt <= w_cnt_inc[CW-1:0];
                end
                r_hold <= (w_cnt_inc >= MAX_WAIT_W);
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: stimulus queues expected writes, a negedge monitor checks every port write.
module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic [4:0]  ex_rd_addr_i;
    logic [31:0] ex_rd_data_i;
    logic        ex_reg_wen_i;
    logic        ll_valid_i;
    logic        ll_ready_o;
    logic [4:0]  ll_rd_addr_i;
    logic [31:0] ll_rd_data_i;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        reg_wen_o;
    logic        hold_o;
    logic        ll_pending_o;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;

    wb_arbiter #(.MAX_WAIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_rd_addr_i (ex_rd_addr_i),
        .ex_rd_data_i (ex_rd_data_i),
        .ex_reg_wen_i (ex_reg_wen_i),
        .ll_valid_i   (ll_valid_i),
        .ll_ready_o   (ll_ready_o),
        .ll_rd_addr_i (ll_rd_addr_i),
        .ll_rd_data_i (ll_rd_data_i),
        .rd_addr_o    (rd_addr_o),
        .rd_data_o    (rd_data_o),
        .reg_wen_o    (reg_wen_o),
        .hold_o       (hold_o),
        .ll_pending_o (ll_pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ex_reg_wen_i = 1'b0;
        ex_rd_addr_i = '0;
        ex_rd_data_i = '0;
        ll_valid_i   = 1'b0;
        ll_rd_addr_i = '0;
        ll_rd_data_i = '0;
    endtask

    // Monitor: every port write must match the oldest expected write
    always @(negedge clk) begin
        if (reg_wen_o === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got rd=%0d data=%h expected no write", rd_addr_o, rd_data_o);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (rd_addr_o !== e.addr || rd_data_o !== e.data) begin
                    errors++;
                    $display("FAIL write_order got rd=%0d data=%h expected rd=%0d data=%h",
                             rd_addr_o, rd_data_o, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        // Reset with every request active
        rst          = 1'b1;
        ex_reg_wen_i = 1'b1;
        ex_rd_addr_i = 5'd5;
        ex_rd_data_i = 32'h1111_1111;
        ll_valid_i   = 1'b1;
        ll_rd_addr_i = 5'd12;
        ll_rd_data_i = 32'h2222_2222;
        for (int i = 0; i < 2; i++) begin
            neg();
            chk("rst_wen", 32'(reg_wen_o), 32'd0);
            chk("rst_ready", 32'(ll_ready_o), 32'd0);
            chk("rst_hold", 32'(hold_o), 32'd0);
            chk("rst_addr", 32'(rd_addr_o), 32'd0);
            chk("rst_data", rd_data_o, 32'd0);
        end
        tick();
        rst = 1'b0;
        idle_inputs();
        neg();
        chk("post_rst_ready", 32'(ll_ready_o), 32'd1);
        chk("post_rst_pending", 32'(ll_pending_o), 32'd0);

        // Ex only, then ex to x0
        tick();
        ex_reg_wen_i = 1'b1; ex_rd_addr_i = 5'd5; ex_rd_data_i = 32'h0000_1234;
        exp_wr(5'd5, 32'h0000_1234);
        neg();
        tick();
        ex_rd_addr_i = 5'd0; ex_rd_data_i = 32'hDEAD_BEEF;
        neg();
        chk("ex_x0_wen", 32'(reg_wen_o), 32'd0);
        tick();
        idle_inputs();
        neg();
        chk("ex_sb_empty", 32'(sb.size()), 32'd0);

        // Conflict: ll buffered behind continuous ex writes until hold forces it
        tick();
        ex_reg_wen_i = 1'b1; ex_rd_addr_i = 5'd3; ex_rd_data_i = 32'h3000_0000;
        ll_valid_i = 1'b1; ll_rd_addr_i = 5'd7; ll_rd_data_i = 32'hA5A5_A5A5;
        exp_wr(5'd3, 32'h3000_0000);
        neg();
        chk("cf_ready_c0", 32'(ll_ready_o), 32'd1);
        for (int c = 1; c <= 4; c++) begin
            tick();
            ll_valid_i = 1'b0;
            ex_rd_data_i = 32'h3000_0000 + 32'(c);
            exp_wr(5'd3, ex_rd_data_i);
            neg();
            chk("cf_hold_low", 32'(hold_o), 32'd0);
            chk("cf_pending", 32'(ll_pending_o), 32'd1);
            chk("cf_ready_low", 32'(ll_ready_o), 32'd0);
        end
        tick();
        ex_rd_data_i = 32'h3000_0005;
        exp_wr(5'd7, 32'hA5A5_A5A5);
        neg();
        chk("cf_hold_high", 32'(hold_o), 32'd1);
        tick();
        ex_rd_data_i = 32'h3000_0006;
        exp_wr(5'd3, 32'h3000_0006);
        neg();
        chk("cf_hold_one_cycle", 32'(hold_o), 32'd0);
        chk("cf_ready_back", 32'(ll_ready_o), 32'd1);
        chk("cf_pending_clr", 32'(ll_pending_o), 32'd0);
        tick();
        idle_inputs();
        neg();
        chk("cf_sb_empty", 32'(sb.size()), 32'd0);

        // Idle-port ll result
        tick();
        ll_valid_i = 1'b1; ll_rd_addr_i = 5'd9; ll_rd_data_i = 32'h0000_0099;
`ifdef WB_BYPASS_EN
        exp_wr(5'd9, 32'h0000_0099);
`endif
        neg();
        chk("idle_ready", 32'(ll_ready_o), 32'd1);
        tick();
        idle_inputs();
`ifdef WB_BYPASS_EN
        neg();
        chk("idle_pending", 32'(ll_pending_o), 32'd0);
`else
        exp_wr(5'd9, 32'h0000_0099);
        neg();
        chk("idle_pending", 32'(ll_pending_o), 32'd1);
`endif
        tick();
        neg();
        chk("idle_sb_empty", 32'(sb.size()), 32'd0);

        // ll handshake to x0 is accepted and discarded
        tick();
        ll_valid_i = 1'b1; ll_rd_addr_i = 5'd0; ll_rd_data_i = 32'h0BAD_0BAD;
        neg();
        chk("x0_ready", 32'(ll_ready_o), 32'd1);
        tick();
        idle_inputs();
        neg();
        chk("x0_pending", 32'(ll_pending_o), 32'd0);
        chk("x0_ready_after", 32'(ll_ready_o), 32'd1);

        // Back-to-back ll results with ex idle
        tick();
        ll_valid_i = 1'b1; ll_rd_addr_i = 5'd10; ll_rd_data_i = 32'h0000_00AA;
`ifdef WB_BYPASS_EN
        exp_wr(5'd10, 32'h0000_00AA);
`endif
        neg();
        chk("b2b_ready0", 32'(ll_ready_o), 32'd1);
        tick();
        ll_rd_addr_i = 5'd11; ll_rd_data_i = 32'h0000_00BB;
`ifdef WB_BYPASS_EN
        exp_wr(5'd11, 32'h0000_00BB);
        neg();
        chk("b2b_ready1", 32'(ll_ready_o), 32'd1);
        tick();
        idle_inputs();
        neg();
`else
        exp_wr(5'd10, 32'h0000_00AA);
        neg();
        chk("b2b_stall", 32'(ll_ready_o), 32'd0);
        tick();
        neg();
        chk("b2b_ready2", 32'(ll_ready_o), 32'd1);
        tick();
        idle_inputs();
        exp_wr(5'd11, 32'h0000_00BB);
        neg();
`endif
        tick();
        neg();
        chk("b2b_sb_empty", 32'(sb.size()), 32'd0);

        // Reset while the buffer holds rd=12
        tick();
        ex_reg_wen_i = 1'b1; ex_rd_addr_i = 5'd4; ex_rd_data_i = 32'h0000_0044;
        ll_valid_i = 1'b1; ll_rd_addr_i = 5'd12; ll_rd_data_i = 32'h0000_0CCC;
        exp_wr(5'd4, 32'h0000_0044);
        neg();
        tick();
        idle_inputs();
        rst = 1'b1;
        neg();
        chk("rf_pending_before", 32'(ll_pending_o), 32'd1);
        chk("rf_wen_in_rst", 32'(reg_wen_o), 32'd0);
        tick();
        rst = 1'b0;
        neg();
        chk("rf_pending_after", 32'(ll_pending_o), 32'd0);
        chk("rf_ready_after", 32'(ll_ready_o), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            neg();
        end
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter for the single register-file write port of the core. It shares the port between two sources. The first is the single-cycle ex stage result, which has priority and cannot be back-pressured. The second is a long-latency unit result (divider or load path), which arrives on a valid/ready handshake into a one-entry holding buffer. A wait counter bounds the starvation of the buffered result: when it expires, the block raises `hold_o` to stall the pipeline for one cycle and forces the buffered write.

## Interface
Parameters:
- `MAX_WAIT`, default 4: number of blocked cycles a buffered result tolerates before `hold_o` is raised. Legal range 1..15.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `ex_rd_addr_i`  in  5  ex-stage destination register.
- `ex_rd_data_i`  in  32  ex-stage write data.
- `ex_reg_wen_i`  in  1  ex-stage write request.
- `ll_valid_i`  in  1  long-latency result valid.
- `ll_ready_o`  out  1  buffer can accept a long-latency result.
- `ll_rd_addr_i`  in  5  long-latency destination register.
- `ll_rd_data_i`  in  32  long-latency write data.
- `rd_addr_o`  out  5  register-file write address.
- `rd_data_o`  out  32  register-file write data.
- `reg_wen_o`  out  1  register-file write enable.
- `hold_o`  out  1  pipeline stall request, registered.
- `ll_pending_o`  out  1  buffer occupied.

## Operation
- **State:**
  - `buf_full`, `buf_addr[4:0]`, `buf_data[31:0]`.
  - `wait_cnt[3:0]`.
  - `hold_o` register.
- **Effective write requests:**
  - The ex request is `ex_reg_wen_i && ex_rd_addr_i != 0`.
  - A handshake to x0 is accepted and discarded. The buffer is not loaded and no write occurs.
- **Grant priority (combinational, evaluated each cycle):**
  1. `hold_o`=1: the buffer writes. The ex request is ignored and dropped; the stalled pipeline replays that instruction.
  2. Otherwise, an effective ex request: the ex stage writes.
  3. Otherwise, `buf_full`: the buffer writes.
  4. Otherwise, under `WB_BYPASS_EN` only, with `ll_valid_i` and a nonzero `ll_rd_addr_i`: the ll result writes directly and is not buffered.
  5. Otherwise: `reg_wen_o`=0 and `rd_addr_o`/`rd_data_o`=0.
- **Handshake:**
  - `ll_ready_o = !rst && !buf_full`. It does not depend on a same-cycle drain.
  - A transfer occurs when `ll_valid_i && ll_ready_o`. The buffer is loaded unless the transfer was bypassed or targets x0.
- **Drain:** `buf_full` clears on the edge ending a cycle in which the buffer was granted. Load and drain are never in the same cycle, because ready=0 while the buffer is full.
- **Wait counter:**
  - Cleared on load and on drain.
  - Increments on each edge where the buffer is full and not granted; saturates at 15.
- **Hold:**
  - `hold_o` is set at the edge where the buffer stays full, is not granted, and `wait_cnt+1 >= MAX_WAIT`.
  - `hold_o` is cleared at the next edge, when the forced drain occurs.
  - Hold is therefore always exactly one cycle.
- **Hazards:** WAW ordering between ex and ll to the same rd is the upstream scoreboard's responsibility. This block only arbitrates.

## Timing
- **Reset** (synchronous, takes effect on the edge with `rst`=1):
  - State after reset: `buf_full`=0, `wait_cnt`=0, `hold_o`=0, `ll_pending_o`=0.
  - Outputs while `rst` is high: `reg_wen_o`=0, `ll_ready_o`=0, `rd_addr_o`=0, `rd_data_o`=0.
  - Reset mid-operation discards any buffered result.
- **Ex path:** combinational, zero cycles from `ex_*` inputs to the write port.
- **Ll path:**
  - Without bypass: minimum 1 cycle from handshake to write.
  - With bypass: 0 cycles when the port is idle.
- **Worst case:** a buffered result writes no later than `MAX_WAIT`+1 cycles after load.
- **Throughput:** `ll_ready_o` returns high on the edge after the drain cycle.

## Configuration
- `WB_BYPASS_EN` defined: grant step 4 is active. An idle-port ll result writes in the same cycle, and the buffer is not loaded.
- `WB_BYPASS_EN` undefined: every accepted nonzero-rd ll result goes through the buffer, so ll latency is at least 1 cycle. The `reg_wen_o` path has no combinational dependence on `ll_*` inputs.

## Test plan
- **Reset:** hold `rst` for 2 cycles with all requests active -> `reg_wen_o`=0, `ll_ready_o`=0, `hold_o`=0. The first cycle after reset has `ll_ready_o`=1.
- **Ex only:** `ex_reg_wen_i`=1, rd=5, data=0x1234 -> same cycle, `reg_wen_o`=1, `rd_addr_o`=5, `rd_data_o`=0x1234. Repeat with rd=0 -> `reg_wen_o`=0.
- **Conflict:**
  - Stimulus: ll rd=7, data=0xA5A5A5A5 accepted while ex writes rd=3 every cycle, `MAX_WAIT`=4.
  - Ex wins for 4 cycles, then `hold_o`=1 for exactly one cycle. In that cycle, the port writes rd=7/0xA5A5A5A5 and the ex write is suppressed.
  - `ll_ready_o` is high on the following cycle.
- **Idle-port ll:**
  - Without the macro: write rd=9 appears one cycle after the handshake.
  - With `WB_BYPASS_EN`: write rd=9 appears in the handshake cycle, and `ll_pending_o` stays 0.
- **Back-to-back ll:** two consecutive valid results with ex idle -> the second is stalled by `ll_ready_o`=0 for one cycle, and both write in order.
- **Reset while buffer full:** rd=12 pending when reset is asserted -> the rd=12 write never appears, and `ll_pending_o`=0 after reset.
